sppm_tx: RTL

- Transmit-side counterpart of the SPPM bin/coincidence receiver.
- Takes one pulse-position symbol per frame over a valid/ready handshake and holds it in a one-entry buffer.
- Emits a PULSE_W-slot-wide pulse at that slot offset after each syn frame marker, one slot per clk.
- Drives the optical/emulator path that feeds the receiver in loopback tests.

---
 rtl/sppm_pkg.sv | 24 ++
 rtl/sppm_sym_buf.sv | 46 ++++
 rtl/sppm_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sppm_pkg.sv
// Shared SPPM constants, FSM state type and PRBS LFSR helpers.
// Used by both the transmitter and the receiver side of the link.
package sppm_pkg;

  localparam int unsigned SPPM_SLOTS   = 101;
  localparam int unsigned SPPM_POS_W   = 7;
  localparam int unsigned SPPM_PULSE_W = 3;
  localparam int unsigned SPPM_MIN_POS = 2;

  localparam int unsigned SPPM_LFSR_W  = 7;
  localparam logic [SPPM_LFSR_W-1:0] SPPM_LFSR_SEED = 7'h01;
  // x^7 + x^6 + 1: feedback from bits 6 and 5
  localparam logic [SPPM_LFSR_W-1:0] SPPM_LFSR_TAPS = 7'h60;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } sppm_state_e;

  function automatic logic [SPPM_LFSR_W-1:0] sppm_lfsr_step(input logic [SPPM_LFSR_W-1:0] v);
    return {v[SPPM_LFSR_W-2:0], ^(v & SPPM_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sppm_sym_buf.sv
// One-entry valid/ready holding buffer for SPPM symbols with legal-range check.
// Out-of-range symbols are consumed and flagged with a one-cycle err_range pulse.
module sppm_sym_buf
  import sppm_pkg::*;
#(
  parameter int unsigned SLOTS   = SPPM_SLOTS,
  parameter int unsigned POS_W   = SPPM_POS_W,
  parameter int unsigned PULSE_W = SPPM_PULSE_W,
  parameter int unsigned MIN_POS = SPPM_MIN_POS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [POS_W-1:0] sym_pos,
  input  logic             take,
  output logic             sym_ready,
  output logic             full,
  output logic [POS_W-1:0] pos,
  output logic             err_range
);

  logic accept_c;
  logic in_range_c;

  // Ready depends only on buffer occupancy, never on sym_valid
  assign sym_ready  = ~full;
  assign accept_c   = sym_valid & ~full;
  assign in_range_c = (32'(sym_pos) >= MIN_POS) && (32'(sym_pos) <= (SLOTS - PULSE_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 1'b0;
      pos       <= '0;
      err_range <= 1'b0;
    end else begin
      err_range <= accept_c & ~in_range_c;
      if (accept_c && in_range_c) begin
        full <= 1'b1;
        pos  <= sym_pos;
      end else if (take) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sppm_tx.sv
// SPPM transmitter: one buffered pulse-position symbol per syn-delimited frame.
// Optional SPPM_TX_PRBS_EN fills underrun frames with LFSR-derived positions.
module sppm_tx
  import sppm_pkg::*;
#(
  parameter int unsigned SLOTS   = SPPM_SLOTS,
  parameter int unsigned POS_W   = SPPM_POS_W,
  parameter int unsigned PULSE_W = SPPM_PULSE_W,
  parameter int unsigned MIN_POS = SPPM_MIN_POS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             syn,
  input  logic             sym_valid,
  input  logic [POS_W-1:0] sym_pos,
  output logic             sym_ready,
  output logic             out,
  output logic             busy,
  output logic             err_range,
  output logic             underrun
);

  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned CMP_W  = ((SLOT_W > POS_W) ? SLOT_W : POS_W) + 1;

  if ((2 ** POS_W) < SLOTS) begin : g_pos_w_chk
    $error("sppm_tx: POS_W too narrow for SLOTS");
  end

  sppm_state_e        state_q, state_d;
  logic [SLOT_W-1:0]  slot_q;
  logic [POS_W-1:0]   act_pos_q;
  logic               act_en_q;
  logic               buf_full;
  logic [POS_W-1:0]   buf_pos;
  logic               take_c;
  logic               slot_last_c;
  logic               hit_c;
  logic               out_d;
  logic               underrun_d;
  logic               load_en_c;
  logic [POS_W-1:0]   load_pos_c;
  logic [CMP_W-1:0]   slot_e;
  logic [CMP_W-1:0]   pos_e;

  sppm_sym_buf #(
    .SLOTS   (SLOTS),
    .POS_W   (POS_W),
    .PULSE_W (PULSE_W),
    .MIN_POS (MIN_POS)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym_pos   (sym_pos),
    .take      (take_c),
    .sym_ready (sym_ready),
    .full      (buf_full),
    .pos       (buf_pos),
    .err_range (err_range)
  );

`ifdef SPPM_TX_PRBS_EN
  if ((MIN_POS + 63) > (SLOTS - PULSE_W)) begin : g_prbs_chk
    $error("sppm_tx: PRBS position range exceeds legal slot range");
  end

  logic [SPPM_LFSR_W-1:0] lfsr_q;

  // Advances once per underrun frame
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SPPM_LFSR_SEED;
    end else if (syn && !buf_full) begin
      lfsr_q <= sppm_lfsr_step(lfsr_q);
    end
  end
`endif

  assign slot_last_c = (slot_q == SLOT_W'(SLOTS - 1));
  assign slot_e      = CMP_W'(slot_q);
  assign pos_e       = CMP_W'(act_pos_q);
  assign hit_c       = (slot_e >= pos_e) && (slot_e < (pos_e + CMP_W'(PULSE_W)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (syn) begin
      state_d = S_RUN;
    end else if ((state_q == S_RUN) && slot_last_c) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    take_c     = 1'b0;
    load_en_c  = 1'b0;
    load_pos_c = buf_pos;
    underrun_d = 1'b0;
    out_d      = 1'b0;
    busy       = (state_q == S_RUN);
    if (state_q == S_RUN) begin
      out_d = act_en_q & hit_c;
    end
    if (syn) begin
      if (buf_full) begin
        take_c    = 1'b1;
        load_en_c = 1'b1;
      end else begin
        underrun_d = 1'b1;
`ifdef SPPM_TX_PRBS_EN
        load_en_c  = 1'b1;
        load_pos_c = POS_W'(MIN_POS) + POS_W'(lfsr_q[5:0]);
`endif
      end
    end
  end

  // Slot counter, active symbol and registered pulse output
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      act_pos_q <= '0;
      act_en_q  <= 1'b0;
      out       <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      out      <= out_d;
      underrun <= underrun_d;
      if (syn) begin
        slot_q   <= '0;
        act_en_q <= load_en_c;
        if (load_en_c) begin
          act_pos_q <= load_pos_c;
        end
      end else if (state_q == S_RUN) begin
        slot_q <= slot_last_c ? '0 : slot_q + SLOT_W'(1);
      end
    end
  end

endmodule
